// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Package     : display_pkg
// Description : Shared constants and types for the card-map display path:
//               map geometry, card-code range, arbiter FSM states and
//               requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int ROWS       = 8;
  localparam int COLS       = 18;
  localparam int CARD_W     = 6;
  localparam int NUM_POS    = ROWS * COLS;
  localparam int EMPTY_CODE = 63;
  // Valid card codes are 0 .. CARD_LIMIT-1.
  localparam int CARD_LIMIT = 54;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef enum logic {
    REQ_LOC = 1'b0,
    REQ_REM = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter. Grant is combinational; the
//               last-grant register advances only when update_i confirms
//               that the offered grant was taken.
// Ports       : clk, rst (async active-low)
//               req_loc_i / req_rem_i : request levels
//               update_i              : grant consumed this cycle
//               gnt_valid_o, gnt_id_o : offered grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import display_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_loc_i,
  input  logic    req_rem_i,
  input  logic    update_i,
  output logic    gnt_valid_o,
  output req_id_t gnt_id_o
);

  req_id_t last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Starting from REM makes LOC win the first tie.
      last_q <= REQ_REM;
    end else if (update_i && gnt_valid_o) begin
      last_q <= gnt_id_o;
    end
  end

  always_comb begin
    gnt_valid_o = req_loc_i | req_rem_i;
    gnt_id_o    = REQ_LOC;
    if (req_loc_i && req_rem_i) begin
      gnt_id_o = (last_q == REQ_LOC) ? REQ_REM : REQ_LOC;
    end else if (req_rem_i) begin
      gnt_id_o = REQ_REM;
    end
  end

endmodule
`default_nettype wire

// File: rtl/map_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : map_write_arbiter
// Description : Owns the card map and selection mask. Arbitrates the single
//               map write port between the local game FSM and the interboard
//               receiver (round robin, req/ack), sequences full-map clears
//               one entry per cycle and applies local selection toggles.
// Ports       : clk, rst (async active-low)
//               loc_req/loc_pos/loc_card -> loc_ack   local write handshake
//               rem_req/rem_pos/rem_card -> rem_ack   interboard write
//               clr_req -> busy, clr_done             full-map clear
//               tog_req/tog_pos                       selection toggle
//               err_pos                               out-of-range write
//               map, sel_card                         flat display buses
// Revision    : 1.0 - initial release
// ============================================================================
module map_write_arbiter
  import display_pkg::*;
#(
  parameter int ROWS       = display_pkg::ROWS,
  parameter int COLS       = display_pkg::COLS,
  parameter int CARD_W     = display_pkg::CARD_W,
  parameter int EMPTY_CODE = display_pkg::EMPTY_CODE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        loc_req,
  input  logic [7:0]                  loc_pos,
  input  logic [CARD_W-1:0]           loc_card,
  output logic                        loc_ack,
  input  logic                        rem_req,
  input  logic [7:0]                  rem_pos,
  input  logic [CARD_W-1:0]           rem_card,
  output logic                        rem_ack,
  input  logic                        clr_req,
  output logic                        clr_done,
  input  logic                        tog_req,
  input  logic [7:0]                  tog_pos,
  output logic                        busy,
  output logic                        err_pos,
  output logic [ROWS*COLS*CARD_W-1:0] map,
  output logic [ROWS*COLS-1:0]        sel_card
);

  localparam int                c_NUM   = ROWS * COLS;
  localparam int                c_MAP_W = c_NUM * CARD_W;
  localparam int                c_IW    = $clog2(c_MAP_W);
  localparam logic [7:0]        c_NUM8  = 8'(c_NUM);
  localparam logic [7:0]        c_LAST8 = 8'(c_NUM - 1);
  localparam logic [CARD_W-1:0] c_EMPTY = CARD_W'(EMPTY_CODE);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [c_MAP_W-1:0]   map_q, map_d;
  logic [c_NUM-1:0]     sel_q, sel_d;
  logic                 loc_ack_q, loc_ack_d;
  logic                 rem_ack_q, rem_ack_d;
  logic                 clr_done_q, clr_done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 w_gnt_valid;
  req_id_t              w_gnt_id;
  logic                 w_gnt_take;
  logic [7:0]           w_pos;
  logic [CARD_W-1:0]    w_card;
  logic [c_IW-1:0]      w_wr_base;
  logic [c_IW-1:0]      w_clr_base;

  // Grants are only consumed in IDLE when no clear is waiting.
  assign w_gnt_take = (state_q == ST_IDLE) && !clr_pend_q && w_gnt_valid;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_loc_i   (loc_req),
    .req_rem_i   (rem_req),
    .update_i    (w_gnt_take),
    .gnt_valid_o (w_gnt_valid),
    .gnt_id_o    (w_gnt_id)
  );

  assign w_pos      = (w_gnt_id == REQ_LOC) ? loc_pos  : rem_pos;
  assign w_card     = (w_gnt_id == REQ_LOC) ? loc_card : rem_card;
  assign w_wr_base  = c_IW'(w_pos) * c_IW'(CARD_W);
  assign w_clr_base = c_IW'(cnt_q) * c_IW'(CARD_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      clr_pend_q <= 1'b0;
      map_q      <= {c_NUM{c_EMPTY}};
      sel_q      <= '0;
      loc_ack_q  <= 1'b0;
      rem_ack_q  <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      map_q      <= map_d;
      sel_q      <= sel_d;
      loc_ack_q  <= loc_ack_d;
      rem_ack_q  <= rem_ack_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    map_d      = map_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    loc_ack_d  = 1'b0;
    rem_ack_d  = 1'b0;
    clr_done_d = 1'b0;
    err_d      = 1'b0;
    // A clear request arriving during CLEAR merges into the running clear.
    clr_pend_d = clr_pend_q | (clr_req && (state_q != ST_CLEAR));

    // Toggle is applied first so that a same-edge granted write overrides it.
    if (tog_req && (state_q != ST_CLEAR) && (tog_pos < c_NUM8)) begin
      sel_d[tog_pos] = ~sel_q[tog_pos];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d    = ST_CLEAR;
          cnt_d      = 8'd0;
          busy_d     = 1'b1;
          clr_pend_d = 1'b0;
        end else if (w_gnt_valid) begin
          if (w_pos < c_NUM8) begin
            map_d[w_wr_base +: CARD_W] = w_card;
            sel_d[w_pos]               = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          loc_ack_d = (w_gnt_id == REQ_LOC);
          rem_ack_d = (w_gnt_id == REQ_REM);
          state_d   = ST_ACK;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      ST_CLEAR: begin
        map_d[w_clr_base +: CARD_W] = c_EMPTY;
        sel_d[cnt_q]                = 1'b0;
        cnt_d                       = cnt_q + 8'd1;
        if (cnt_q == c_LAST8) begin
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign loc_ack  = loc_ack_q;
  assign rem_ack  = rem_ack_q;
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
  assign err_pos  = err_q;
  assign map      = map_q;
  assign sel_card = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_map_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_write_arbiter
// Description : Directed self-checking bench for map_write_arbiter. Inputs
//               change on the falling edge; outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_write_arbiter;

  localparam int c_NUM = 144;
  localparam int c_W   = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   loc_req, rem_req, clr_req, tog_req;
  logic [7:0]             loc_pos, rem_pos, tog_pos;
  logic [c_W-1:0]         loc_card, rem_card;
  logic                   loc_ack, rem_ack, clr_done, busy, err_pos;
  logic [c_NUM*c_W-1:0]   map;
  logic [c_NUM-1:0]       sel_card;

  logic [c_NUM*c_W-1:0]   exp_map;
  logic [c_NUM-1:0]       exp_sel;
  int                     n_checks = 0;
  int                     n_err    = 0;
  int                     busy_cnt;
  int                     done_cnt;
  logic                   any_ack;

  always #5 clk = ~clk;

  map_write_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .loc_req  (loc_req),
    .loc_pos  (loc_pos),
    .loc_card (loc_card),
    .loc_ack  (loc_ack),
    .rem_req  (rem_req),
    .rem_pos  (rem_pos),
    .rem_card (rem_card),
    .rem_ack  (rem_ack),
    .clr_req  (clr_req),
    .clr_done (clr_done),
    .tog_req  (tog_req),
    .tog_pos  (tog_pos),
    .busy     (busy),
    .err_pos  (err_pos),
    .map      (map),
    .sel_card (sel_card)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [c_NUM*c_W-1:0] obs,
                      input logic [c_NUM*c_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    loc_req = 0; rem_req = 0; clr_req = 0; tog_req = 0;
    loc_pos = 0; rem_pos = 0; tog_pos = 0; loc_card = 0; rem_card = 0;
    exp_map = {c_NUM{6'd63}};
    exp_sel = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chkw("rst_map", map, exp_map);
    chkw("rst_sel", {720'd0, sel_card}, {720'd0, exp_sel});
    chk("rst_outs", {27'd0, loc_ack, rem_ack, clr_done, err_pos, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single local write: pos 5, card 12 (last_grant becomes LOC)
    loc_req = 1; loc_pos = 8'd5; loc_card = 6'd12;
    @(negedge clk);
    exp_map[5*c_W +: c_W] = 6'd12;
    chk("t1_ack", loc_ack, 1);
    chkw("t1_map", map, exp_map);
    loc_req = 0;
    @(negedge clk);
    chk("t1_ack_low", loc_ack, 0);

    // Out-of-range interboard write (last_grant becomes REM)
    rem_req = 1; rem_pos = 8'd150; rem_card = 6'd5;
    @(negedge clk);
    chk("oor_ack", rem_ack, 1);
    chk("oor_err", err_pos, 1);
    chkw("oor_map", map, exp_map);
    chkw("oor_sel", {720'd0, sel_card}, {720'd0, exp_sel});
    rem_req = 0;
    @(negedge clk);
    chk("oor_err_low", {30'd0, err_pos, rem_ack}, 0);

    // Contention after a REM grant: LOC first, REM two cycles later
    loc_req = 1; loc_pos = 8'd21; loc_card = 6'd8;
    rem_req = 1; rem_pos = 8'd20; rem_card = 6'd7;
    @(negedge clk);
    exp_map[21*c_W +: c_W] = 6'd8;
    chk("c1_first", {30'd0, loc_ack, rem_ack}, 32'b10);
    chkw("c1_map_loc", map, exp_map);
    loc_req = 0;
    @(negedge clk);
    chk("c1_gap", {30'd0, loc_ack, rem_ack}, 32'b00);
    @(negedge clk);
    exp_map[20*c_W +: c_W] = 6'd7;
    chk("c1_second", {30'd0, loc_ack, rem_ack}, 32'b01);
    chkw("c1_map_rem", map, exp_map);
    rem_req = 0;
    @(negedge clk);

    // Local-only write so LOC was last, then contention: REM first
    loc_req = 1; loc_pos = 8'd24; loc_card = 6'd3;
    @(negedge clk);
    exp_map[24*c_W +: c_W] = 6'd3;
    chk("w24_ack", loc_ack, 1);
    loc_req = 0;
    @(negedge clk);
    loc_req = 1; loc_pos = 8'd22; loc_card = 6'd1;
    rem_req = 1; rem_pos = 8'd23; rem_card = 6'd2;
    @(negedge clk);
    exp_map[23*c_W +: c_W] = 6'd2;
    chk("c2_first", {30'd0, loc_ack, rem_ack}, 32'b01);
    rem_req = 0;
    @(negedge clk);
    @(negedge clk);
    exp_map[22*c_W +: c_W] = 6'd1;
    chk("c2_second", {30'd0, loc_ack, rem_ack}, 32'b10);
    chkw("c2_map", map, exp_map);
    loc_req = 0;
    @(negedge clk);

    // Toggle pos 3, then an out-of-range toggle that must be ignored
    tog_req = 1; tog_pos = 8'd3;
    @(negedge clk);
    exp_sel[3] = 1'b1;
    tog_pos = 8'd200;
    chkw("tog3", {720'd0, sel_card}, {720'd0, exp_sel});
    @(negedge clk);
    tog_req = 0;
    chkw("tog_oor", {720'd0, sel_card}, {720'd0, exp_sel});

    // Clear with a local request raised during CLEAR
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    chk("clr_pending_busy", busy, 0);
    @(negedge clk);
    chk("clr_busy_start", busy, 1);
    loc_req = 1; loc_pos = 8'd0; loc_card = 6'd9;
    busy_cnt = 0; done_cnt = 0; any_ack = 0;
    while (busy === 1'b1 && busy_cnt < 400) begin
      busy_cnt++;
      if (loc_ack) any_ack = 1'b1;
      if (clr_done) done_cnt++;
      clr_req = (busy_cnt == 10);   // merged into the running clear
      @(negedge clk);
    end
    clr_req = 0;
    exp_map = {c_NUM{6'd63}};
    exp_sel = '0;
    chk("clr_len", busy_cnt, 144);
    chk("clr_no_ack", {31'd0, any_ack}, 0);
    chk("clr_done_early", done_cnt, 0);
    chk("clr_done", clr_done, 1);
    chkw("clr_map", map, exp_map);
    chkw("clr_sel", {720'd0, sel_card}, {720'd0, exp_sel});
    @(negedge clk);
    exp_map[0 +: c_W] = 6'd9;
    chk("post_clr_ack", {30'd0, loc_ack, clr_done}, 32'b10);
    chkw("post_clr_map", map, exp_map);
    loc_req = 0;
    @(negedge clk);
    chk("post_clr_busy", busy, 0);

    // Toggle 40 set, then toggle and write to 40 on the same edge
    tog_req = 1; tog_pos = 8'd40;
    @(negedge clk);
    tog_req = 0;
    exp_sel[40] = 1'b1;
    chkw("tog40", {720'd0, sel_card}, {720'd0, exp_sel});
    tog_req = 1; loc_req = 1; loc_pos = 8'd40; loc_card = 6'd17;
    @(negedge clk);
    tog_req = 0; loc_req = 0;
    exp_sel[40] = 1'b0;
    exp_map[40*c_W +: c_W] = 6'd17;
    chkw("tw_sel", {720'd0, sel_card}, {720'd0, exp_sel});
    chkw("tw_map", map, exp_map);
    chk("tw_ack", loc_ack, 1);
    @(negedge clk);

    // Reset in the middle of a clear
    loc_req = 1; loc_pos = 8'd100; loc_card = 6'd30;
    @(negedge clk);
    loc_req = 0;
    exp_map[100*c_W +: c_W] = 6'd30;
    @(negedge clk);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    @(negedge clk);
    repeat (70) @(negedge clk);
    exp_map[0 +: c_W]      = 6'd63;
    exp_map[40*c_W +: c_W] = 6'd63;
    chkw("mid_clr_map", map, exp_map);
    chk("mid_clr_busy", busy, 1);
    rst = 1'b0;
    #1;
    exp_map = {c_NUM{6'd63}};
    chkw("rst_mid_map", map, exp_map);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {30'd0, busy, clr_done}, 0);
    loc_req = 1; loc_pos = 8'd7; loc_card = 6'd4;
    @(negedge clk);
    exp_map[7*c_W +: c_W] = 6'd4;
    chk("rst_after_ack", loc_ack, 1);
    chkw("rst_after_map", map, exp_map);
    loc_req = 0;
    @(negedge clk);
    chk("rst_after_done", {30'd0, busy, clr_done}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
